uart_rx_frontend: RTL and testbench

- Serial UART receiver that sits directly downstream of the board `rx_i` pin.
- Feeds received bytes to the UART peripheral controller of `riscv_unit`.
- Synchronizes the asynchronous line, detects the start bit, samples 8 data bits LSB-first, an optional even-parity bit and one stop bit.
- Presents each byte with a single-cycle valid strobe plus parity and framing error flags.

---
 rtl/uart_rx_frontend.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// UART receiver front end: 2-FF line synchronizer, start-bit qualification, 8N1/8E1 framing.
// Emits each byte with a one-cycle valid strobe plus parity and framing error flags.
module uart_rx_frontend #(
  parameter int unsigned CLK_FREQ = 10_000_000,
  parameter int unsigned BAUDRATE = 115200
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       rx_i,
  input  logic       parity_en_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned DIV  = CLK_FREQ / BAUDRATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DivLast  = CW'(DIV - 1);
  localparam logic [CW-1:0] HalfLast = CW'(HALF - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic          rx_meta_q, rxs_q, rxs_prev_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          pen_q, pen_d;
  logic          perr_q, perr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_out_q, perr_out_d;
  logic          ferr_q, ferr_d;

  // Synchronizer and edge history idle high so a quiet line never looks like a start.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_i;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    pen_d      = pen_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    unique case (state_q)
      StIdle: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!rxs_q) begin
            pen_d   = parity_en_i;
            bit_d   = '0;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == DivLast) begin
          sh_d  = {rxs_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = pen_q ? StParity : StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (cnt_q == DivLast) begin
          perr_d  = rxs_q ^ (^sh_q);
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        // Back to idle at the stop mid-sample so a zero-gap next start edge is caught.
        if (cnt_q == DivLast) begin
          cnt_d      = '0;
          state_d    = StIdle;
          valid_d    = 1'b1;
          data_d     = sh_q;
          perr_out_d = pen_q & perr_q;
          ferr_d     = ~rxs_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      pen_q      <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      pen_q      <= pen_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed plus randomized frames checked against a bit-level framing model of the receiver.
module tb_uart_rx_frontend;

  localparam int unsigned DIV = 10_000_000 / 115200;

  logic       clk = 1'b0;
  logic       resetn_i;
  logic       rx_i;
  logic       parity_en_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;

  uart_rx_frontend dut (
    .clk_i       (clk),
    .resetn_i    (resetn_i),
    .rx_i        (rx_i),
    .parity_en_i (parity_en_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .parity_err_o(parity_err_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Pulse recorder: every valid_o cycle is logged with its outputs and cycle stamp.
  logic [7:0] p_data [0:255];
  logic       p_perr [0:255];
  logic       p_ferr [0:255];
  int         p_cyc  [0:255];
  int         p_wr = 0;
  int         cyc = 0;
  int         dbl = 0;
  logic       prev_v = 1'b0;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    prev_v <= valid_o;
    if (valid_o) begin
      p_data[p_wr[7:0]] <= data_o;
      p_perr[p_wr[7:0]] <= parity_err_o;
      p_ferr[p_wr[7:0]] <= frame_err_o;
      p_cyc[p_wr[7:0]]  <= cyc;
      p_wr              <= p_wr + 1;
      if (prev_v) dbl <= dbl + 1;
    end
  end

  int rd = 0;
  int last_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx_i = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pen, input logic pbit,
                            input logic stopv);
    parity_en_i = pen;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    if (pen) bit_time(pbit);
    bit_time(stopv);
  endtask

  // Reference: even parity means data plus parity bit carry an even number of ones.
  task automatic expect_pulse(input string tag, input logic [7:0] b, input logic pen,
                              input logic pbit, input logic stopv);
    int waited = 0;
    logic exp_perr;
    exp_perr = pen ? ((($countones(b) + int'(pbit)) % 2) == 1) : 1'b0;
    while (p_wr <= rd && waited < 3 * DIV) begin
      @(negedge clk);
      waited++;
    end
    if (p_wr <= rd) begin
      chk({tag, "_timeout"}, 32'(p_wr), 32'(rd + 1));
    end else begin
      chk({tag, "_data"}, 32'(p_data[rd[7:0]]), 32'(b));
      chk({tag, "_perr"}, 32'(p_perr[rd[7:0]]), 32'(exp_perr));
      chk({tag, "_ferr"}, 32'(p_ferr[rd[7:0]]), 32'(!stopv));
      last_cyc = p_cyc[rd[7:0]];
      rd++;
    end
  endtask

  initial begin
    int c1;
    logic [7:0] rb;
    logic rpen, rpbit, rstop;

    resetn_i    = 1'b0;
    rx_i        = 1'b1;
    parity_en_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_perr", 32'(parity_err_o), 32'h0);
    chk("rst_ferr", 32'(frame_err_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    resetn_i = 1'b1;
    repeat (2 * DIV) @(negedge clk);

    // 1: parity on, correct parity, two stop bits
    send_frame(8'h1C, 1'b1, 1'b1, 1'b1);
    bit_time(1'b1);
    expect_pulse("t1", 8'h1C, 1'b1, 1'b1, 1'b1);
    chk("t1_busy_after", 32'(busy_o), 32'h0);
    chk("t1_one_pulse", 32'(p_wr - rd), 32'h0);

    // 2: parity bit forced wrong
    send_frame(8'h1C, 1'b1, 1'b0, 1'b1);
    bit_time(1'b1);
    expect_pulse("t2", 8'h1C, 1'b1, 1'b0, 1'b1);

    // 3: frame error, line held low (break), then a clean frame
    send_frame(8'h0D, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b0);
    expect_pulse("t3a", 8'h0D, 1'b0, 1'b0, 1'b0);
    chk("t3_no_pulse_low", 32'(p_wr - rd), 32'h0);
    bit_time(1'b1);
    bit_time(1'b1);
    send_frame(8'h0D, 1'b0, 1'b0, 1'b1);
    bit_time(1'b1);
    expect_pulse("t3b", 8'h0D, 1'b0, 1'b0, 1'b1);

    // 4: short glitch must not produce a frame
    rx_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_busy_rise", 32'(busy_o), 32'h1);
    repeat (10) @(negedge clk);
    rx_i = 1'b1;
    repeat (60) @(negedge clk);
    chk("t4_busy_fall", 32'(busy_o), 32'h0);
    chk("t4_no_pulse", 32'(p_wr - rd), 32'h0);
    send_frame(8'h7F, 1'b0, 1'b0, 1'b1);
    bit_time(1'b1);
    expect_pulse("t4", 8'h7F, 1'b0, 1'b0, 1'b1);

    // 5: back-to-back frames with zero idle gap
    send_frame(8'h7F, 1'b0, 1'b0, 1'b1);
    send_frame(8'h7F, 1'b0, 1'b0, 1'b1);
    bit_time(1'b1);
    expect_pulse("t5a", 8'h7F, 1'b0, 1'b0, 1'b1);
    c1 = last_cyc;
    expect_pulse("t5b", 8'h7F, 1'b0, 1'b0, 1'b1);
    chk("t5_gap_ok", 32'((last_cyc - c1 >= 10 * DIV - 2) && (last_cyc - c1 <= 10 * DIV + 2)),
        32'h1);

    // 6: reset during the 4th data bit of 0x5A
    parity_en_i = 1'b0;
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(rb_bit(8'h5A, i));
    rx_i = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    resetn_i = 1'b0;
    #1;
    chk("t6_rst_data", 32'(data_o), 32'h0);
    chk("t6_rst_busy", 32'(busy_o), 32'h0);
    chk("t6_rst_ferr", 32'(frame_err_o), 32'h0);
    repeat (5) @(negedge clk);
    resetn_i = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    chk("t6_no_pulse", 32'(p_wr - rd), 32'h0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    bit_time(1'b1);
    expect_pulse("t6", 8'hA5, 1'b0, 1'b0, 1'b1);

    // Randomized frames
    for (int n = 0; n < 10; n++) begin
      rb    = 8'($urandom);
      rpen  = 1'($urandom_range(0, 1));
      rpbit = 1'($countones(rb) % 2) ^ ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 3) != 0);
      send_frame(rb, rpen, rpbit, rstop);
      bit_time(1'b1);
      bit_time(1'b1);
      expect_pulse("rnd", rb, rpen, rpbit, rstop);
    end

    chk("valid_single_cycle", 32'(dbl), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
